modport_dut: RTL and testbench



---
 rtl/modport_dut_pkg.sv | 25 ++
 rtl/dut_if.sv | 17 +
 rtl/modport_dut_regfile.sv | 42 ++++
 rtl/modport_dut.sv | 85 ++++++++
 tb/tb_modport_dut.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/modport_dut_pkg.sv
// Shared widths, command encodings and the legality check for the modport_dut
// command slave.
package modport_dut_pkg;

   localparam int DEPTH     = 16;
   localparam int W         = 4;
   localparam int ERR_CNT_W = 8;

   typedef enum logic [3:0] {
      CMD_NOP   = 4'd0,
      CMD_WRITE = 4'd1,
      CMD_READ  = 4'd2,
      CMD_CLEAR = 4'd3,
      CMD_INCR  = 4'd4
   } cmd_e;

   // Any code outside the known set, including X/Z in simulation, is illegal.
   function automatic logic is_legal(input logic [W-1:0] cmd);
      case (cmd)
         CMD_NOP, CMD_WRITE, CMD_READ, CMD_CLEAR, CMD_INCR: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dut_if.sv
// Bus carrying command/address/data from a master to the command slave and
// its registered responses back.
interface dut_if;
   import modport_dut_pkg::*;

   logic [W-1:0]         cmd;
   logic [W-1:0]         adr;
   logic [W-1:0]         data;
   logic [W-1:0]         rdata;
   logic                 rvalid;
   logic                 err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (output cmd, adr, data, input rdata, rvalid, err, err_cnt);
   modport slave  (input cmd, adr, data, output rdata, rvalid, err, err_cnt);

endinterface

// File: rtl/modport_dut_regfile.sv
// 16 x 4 register array: one synchronous write port, one registered read
// port, plus a combinational view of the addressed entry for read-modify-write.
module modport_dut_regfile
   import modport_dut_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] adr_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] cur_data_o,
   output logic [W-1:0] rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   // NOTE: the array is small and must read back as zero after reset, so it is
   // built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge
         // values, so a same-cycle read sees the old entry.
         if (wr_en_i) begin
            mem_q[adr_i] <= wr_data_i;
         end
         if (rd_en_i) begin
            rdata_q <= mem_q[adr_i];
         end
      end
   end

   assign cur_data_o = mem_q[adr_i];
   assign rdata_o    = rdata_q;

endmodule

// File: rtl/modport_dut.sv
// Command-decoding slave: decodes one command per clock, drives the register
// file, and reports illegal commands with a pulse and a saturating count.
module modport_dut
   import modport_dut_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [W-1:0]         cmd,
   input  logic [W-1:0]         adr,
   input  logic [W-1:0]         data,
   output logic [W-1:0]         rdata,
   output logic                 rvalid,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic                 wr_en;
   logic [W-1:0]         wr_data;
   logic                 rd_en;
   logic [W-1:0]         cur_data;
   logic                 rvalid_d, rvalid_q;
   logic                 err_d, err_q;
   logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

   // NOTE: every combinational output is defaulted first so no path through
   // the case leaves a signal unassigned and infers a latch.
   always_comb begin
      wr_en     = 1'b0;
      wr_data   = data;
      rd_en     = 1'b0;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      case (cmd)
         CMD_WRITE: wr_en = 1'b1;
         CMD_READ: begin
            rd_en    = 1'b1;
            rvalid_d = 1'b1;
         end
         CMD_CLEAR: begin
            wr_en   = 1'b1;
            wr_data = '0;
         end
         CMD_INCR: begin
            wr_en   = 1'b1;
            wr_data = cur_data + data;   // carry out of the 4-bit sum is dropped
         end
         default: ;
      endcase
      if (!is_legal(cmd)) begin
         err_d = 1'b1;
         if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   modport_dut_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .adr_i      (adr),
      .wr_en_i    (wr_en),
      .wr_data_i  (wr_data),
      .rd_en_i    (rd_en),
      .cur_data_o (cur_data),
      .rdata_o    (rdata)
   );

   assign rvalid  = rvalid_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_modport_dut.sv
// Directed bench for modport_dut driven through a dut_if bus instance; every
// expected value below is hand-computed from the command semantics.
module tb_modport_dut;
   import modport_dut_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   dut_if bus ();

   modport_dut dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (bus.cmd),
      .adr     (bus.adr),
      .data    (bus.data),
      .rdata   (bus.rdata),
      .rvalid  (bus.rvalid),
      .err     (bus.err),
      .err_cnt (bus.err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one command, let it be sampled, and return 1 ns after the edge.
   task automatic step(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
      bus.cmd  = c;
      bus.adr  = a;
      bus.data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      bus.cmd  = CMD_NOP;
      bus.adr  = 4'h0;
      bus.data = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata",   32'(bus.rdata),   32'h0);
      check("reset_rvalid",  32'(bus.rvalid),  32'h0);
      check("reset_err",     32'(bus.err),     32'h0);
      check("reset_err_cnt", 32'(bus.err_cnt), 32'h0);
      rst = 1'b0;

      // Every entry reads back as zero after reset.
      for (int a = 0; a < 16; a++) begin
         step(CMD_READ, 4'(a), 4'h0);
         check($sformatf("init_rvalid_%0d", a), 32'(bus.rvalid), 32'h1);
         check($sformatf("init_rdata_%0d", a),  32'(bus.rdata),  32'h0);
      end
      check("init_err_cnt", 32'(bus.err_cnt), 32'h0);

      // Read-after-write, then rvalid drops and rdata holds.
      step(CMD_WRITE, 4'h5, 4'hA);
      check("wr5_rvalid", 32'(bus.rvalid), 32'h0);
      step(CMD_READ, 4'h5, 4'h0);
      check("rd5_rvalid", 32'(bus.rvalid), 32'h1);
      check("rd5_rdata",  32'(bus.rdata),  32'hA);
      step(CMD_NOP, 4'h0, 4'h0);
      check("nop_rvalid", 32'(bus.rvalid), 32'h0);
      check("nop_rdata_hold", 32'(bus.rdata), 32'hA);

      // INCR wraps modulo 16.
      step(CMD_WRITE, 4'h3, 4'hF);
      step(CMD_INCR,  4'h3, 4'h2);
      step(CMD_READ,  4'h3, 4'h0);
      check("incr_wrap_rdata", 32'(bus.rdata), 32'h1);

      // CLEAR touches only its own entry.
      step(CMD_WRITE, 4'h7, 4'h9);
      step(CMD_CLEAR, 4'h7, 4'h5);
      step(CMD_READ,  4'h7, 4'h0);
      check("clear7_rdata", 32'(bus.rdata), 32'h0);
      step(CMD_READ, 4'h5, 4'h0);
      check("keep5_rdata", 32'(bus.rdata), 32'hA);
      step(CMD_READ, 4'h3, 4'h0);
      check("keep3_rdata", 32'(bus.rdata), 32'h1);

      // Illegal codes pulse err, count, and leave memory alone.
      step(4'd5, 4'h5, 4'h0);
      check("ill5_err",     32'(bus.err),     32'h1);
      check("ill5_rvalid",  32'(bus.rvalid),  32'h0);
      check("ill5_err_cnt", 32'(bus.err_cnt), 32'h1);
      step(CMD_NOP, 4'h0, 4'h0);
      check("nop_err", 32'(bus.err), 32'h0);
      step(4'd15, 4'h5, 4'h7);
      check("ill15_err",     32'(bus.err),     32'h1);
      check("ill15_err_cnt", 32'(bus.err_cnt), 32'h2);
      step(CMD_READ, 4'h5, 4'h0);
      check("ill_mem_rdata", 32'(bus.rdata), 32'hA);
      check("ill_mem_err",   32'(bus.err),   32'h0);

      // 300 more illegal commands: count reaches 255 after 253 of them and holds.
      for (int i = 0; i < 300; i++) begin
         step(4'(5 + (i % 11)), 4'(i), 4'h1);
         if (i == 251) check("sat_254", 32'(bus.err_cnt), 32'd254);
         if (i == 252) check("sat_255", 32'(bus.err_cnt), 32'd255);
      end
      check("sat_hold", 32'(bus.err_cnt), 32'd255);
      check("sat_err",  32'(bus.err),     32'h1);
      step(CMD_READ, 4'h3, 4'h0);
      check("sat_mem_rdata", 32'(bus.rdata), 32'h1);
      check("sat_err_cnt_after", 32'(bus.err_cnt), 32'd255);

      // Reset in the same cycle as a WRITE drops the write and clears everything.
      step(CMD_READ, 4'h5, 4'h0);
      check("pre_rst_rdata", 32'(bus.rdata), 32'hA);
      rst = 1'b1;
      step(CMD_WRITE, 4'h2, 4'h6);
      rst = 1'b0;
      check("rst_rdata",   32'(bus.rdata),   32'h0);
      check("rst_rvalid",  32'(bus.rvalid),  32'h0);
      check("rst_err",     32'(bus.err),     32'h0);
      check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
      step(CMD_READ, 4'h2, 4'h0);
      check("rst_drop_wr2", 32'(bus.rdata),  32'h0);
      check("rst_rd_valid", 32'(bus.rvalid), 32'h1);
      step(CMD_READ, 4'h5, 4'h0);
      check("rst_clear5", 32'(bus.rdata), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
